sbox_inv_small: RTL and testbench

Inverse-direction companion to the 4-bit registered S-box lookup. It holds a programmable forward S-box table and derives the inverse table from it with a sequential sweep, checking that the table is a bijection. It then serves inverse lookups over a valid/ready stream with one cycle of latency. It sits on the decrypt/unmix side of the mining datapath, paired with the forward S-box, and shares the same configuration writes.

---
 rtl/sbox_pkg.sv | 29 ++
 rtl/sbox_inv_builder.sv | 52 +++++
 rtl/sbox_inv_small.sv | 101 ++++++++++
 tb/tb_sbox_inv_small.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sbox_pkg.sv
// Shared constants, types and identity-table init for the forward/inverse 4-bit S-box pair.
package sbox_pkg;

  localparam int SBOX_W     = 4;
  localparam int SBOX_DEPTH = 2**SBOX_W;

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_STALE = 2'd1,
    S_BUILD = 2'd2,
    S_ERR   = 2'd3
  } sbox_state_e;

  typedef logic [SBOX_DEPTH-1:0][SBOX_W-1:0] sbox_tbl_t;

  // One write into the inverse table, driven by the builder during the sweep.
  typedef struct packed {
    logic              we;
    logic [SBOX_W-1:0] addr;
    logic [SBOX_W-1:0] data;
  } inv_wr_t;

  function automatic sbox_tbl_t sbox_identity();
    sbox_tbl_t t;
    for (int i = 0; i < SBOX_DEPTH; i++) t[i] = SBOX_W'(i);
    return t;
  endfunction

endpackage

// File: rtl/sbox_inv_builder.sv
// Inverse-table sweep: walks fwd[0..DEPTH-1], emits inv writes and tracks duplicate outputs.
module sbox_inv_builder
  import sbox_pkg::*;
#(
  parameter int W     = SBOX_W,
  localparam int DEPTH = 2**W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         run,
  input  logic [W-1:0] fwd_val,
  output logic [W-1:0] idx,
  output inv_wr_t      inv_wr,
  output logic         done,
  output logic         dup_final
);

  logic [W:0]       cnt;
  logic [DEPTH-1:0] seen;
  logic             dup;

  assign idx = cnt[W-1:0];

  always_comb begin
    inv_wr      = '0;
    inv_wr.we   = run;
    inv_wr.addr = fwd_val;
    inv_wr.data = idx;
  end

  // The last entry's collision is folded in combinationally so the sweep ends in DEPTH cycles.
  assign done      = run && (cnt == (W+1)'(DEPTH-1));
  assign dup_final = dup | seen[fwd_val];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      seen <= '0;
      dup  <= 1'b0;
    end else if (start) begin
      cnt  <= '0;
      seen <= '0;
      dup  <= 1'b0;
    end else if (run) begin
      cnt           <= cnt + 1'b1;
      seen[fwd_val] <= 1'b1;
      if (seen[fwd_val]) dup <= 1'b1;
    end
  end

endmodule

// File: rtl/sbox_inv_small.sv
// Inverse 4-bit S-box: programmable forward table, sequential inverse build, 1-cycle lookup stream.
// Optional SBOX_INV_SELFCHECK_EN adds a fwd[inv[x]] == x check on every accepted lookup.
module sbox_inv_small
  import sbox_pkg::*;
#(
  parameter int W     = SBOX_W,
  localparam int DEPTH = 2**W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         cfg_commit,
  output logic         cfg_busy,
  output logic         table_ok,
  output logic         table_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         chk_err
);

  sbox_state_e               state;
  logic [DEPTH-1:0][W-1:0]   fwd_tbl;
  logic [DEPTH-1:0][W-1:0]   inv_tbl;

  logic         bld_start, bld_run, bld_done, bld_dup;
  logic [W-1:0] bld_idx;
  inv_wr_t      inv_wr;
  logic         accept;

  assign bld_run   = (state == S_BUILD);
  assign bld_start = cfg_commit && !bld_run;

  sbox_inv_builder #(.W(W)) u_builder (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (bld_start),
    .run       (bld_run),
    .fwd_val   (fwd_tbl[bld_idx]),
    .idx       (bld_idx),
    .inv_wr    (inv_wr),
    .done      (bld_done),
    .dup_final (bld_dup)
  );

  // A same-cycle write and commit both land: the write is in fwd before the sweep reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_READY;
      fwd_tbl <= sbox_identity();
      inv_tbl <= sbox_identity();
    end else begin
      if (cfg_we && !bld_run) fwd_tbl[cfg_addr] <= cfg_data;
      if (inv_wr.we) inv_tbl[inv_wr.addr] <= inv_wr.data;
      case (state)
        S_BUILD: if (bld_done) state <= bld_dup ? S_ERR : S_READY;
        default: begin
          if (cfg_commit)  state <= S_BUILD;
          else if (cfg_we) state <= S_STALE;
        end
      endcase
    end
  end

  assign table_ok  = (state == S_READY);
  assign table_err = (state == S_ERR);
  assign cfg_busy  = bld_run;

  assign in_ready = (state == S_READY) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= inv_tbl[in_data];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SBOX_INV_SELFCHECK_EN
  // Only storage corruption can trip this: a bijective build always round-trips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      chk_err <= 1'b0;
    else if (accept && (fwd_tbl[inv_tbl[in_data]] != in_data))
      chk_err <= 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_sbox_inv_small.sv
// Self-checking bench for sbox_inv_small: directed steps plus random lookups against a table model.
module tb_sbox_inv_small;
  localparam int W = 4;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0, cfg_commit = 1'b0;
  logic [W-1:0] cfg_addr = '0, cfg_data = '0;
  logic         cfg_busy, table_ok, table_err, chk_err;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0] in_data = '0, out_data;

  sbox_inv_small dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .table_ok(table_ok), .table_err(table_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: tables as int arrays, mode 0=ready 1=stale 2=build 3=err.
  int fwd_m[D];
  int inv_m[D];
  int ms;
  int bleft;
  bit mv;
  int md;
  bit chk_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin fwd_m[i] = i; inv_m[i] = i; end
    ms = 0; bleft = 0; mv = 0; md = 0; chk_m = 0;
  endtask

  // Inverse exists iff every output value appears exactly once.
  function automatic bit model_build();
    int hits[D];
    bit ok = 1;
    for (int v = 0; v < D; v++) hits[v] = 0;
    for (int j = 0; j < D; j++) hits[fwd_m[j]]++;
    for (int v = 0; v < D; v++) if (hits[v] != 1) ok = 0;
    if (ok) for (int j = 0; j < D; j++) inv_m[fwd_m[j]] = j;
    return ok;
  endfunction

  task automatic tick();
    bit rdy, acc, we, cm;
    int d, wa, wd;
    #1;
    rdy = (ms == 0) && (!mv || out_ready);
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    d = in_data; we = cfg_we; cm = cfg_commit; wa = cfg_addr; wd = cfg_data;
    @(posedge clk);
    if (acc) begin
      mv = 1; md = inv_m[d];
`ifdef SBOX_INV_SELFCHECK_EN
      if (fwd_m[inv_m[d]] != d) chk_m = 1;
`endif
    end else if (out_ready) mv = 0;
    if (ms != 2) begin
      if (we) fwd_m[wa] = wd;
      if (cm) begin ms = 2; bleft = D; end
      else if (we) ms = 1;
    end else begin
      bleft--;
      if (bleft == 0) ms = model_build() ? 0 : 3;
    end
    #1;
    chk("table_ok", table_ok, ms == 0);
    chk("table_err", table_err, ms == 3);
    chk("cfg_busy", cfg_busy, ms == 2);
    chk("out_valid", out_valid, mv);
    chk("out_data", out_data, md);
    chk("chk_err", chk_err, chk_m);
  endtask

  task automatic step(input bit v, input int d, input bit ordy);
    in_valid = v; in_data = W'(d); out_ready = ordy;
    tick();
  endtask

  task automatic write(input int a, input int d, input bit with_commit);
    in_valid = 0; cfg_we = 1; cfg_addr = W'(a); cfg_data = W'(d); cfg_commit = with_commit;
    tick();
    cfg_we = 0; cfg_commit = 0;
  endtask

  task automatic finish_build(input int already);
    int bc = already;
    int g = 0;
    while (ms == 2 && g < 40) begin
      tick();
      if (cfg_busy) bc++;
      g++;
    end
    chk("busy_cycles", bc, 16);
  endtask

  task automatic commit();
    in_valid = 0; cfg_commit = 1;
    tick();
    cfg_commit = 0;
    finish_build(cfg_busy ? 1 : 0);
  endtask

  task automatic rand_ticks(input int n);
    for (int k = 0; k < n; k++)
      step($urandom % 2, $urandom % D, ($urandom % 4) != 0);
  endtask

  task automatic load_perm(input bit with_dup);
    int p[D];
    for (int i = 0; i < D; i++) p[i] = i;
    for (int i = D - 1; i > 0; i--) begin
      int j = $urandom % (i + 1);
      int t = p[i]; p[i] = p[j]; p[j] = t;
    end
    if (with_dup) p[$urandom % D] = p[0] ^ 1;
    for (int i = 0; i < D - 1; i++) write(i, p[i], 0);
    write(D - 1, p[D - 1], 1);
    finish_build(cfg_busy ? 1 : 0);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_table_ok", table_ok, 1);
    chk("rst_table_err", table_err, 0);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_chk_err", chk_err, 0);
    rst_n = 1'b1;

    // Identity stream, one per cycle.
    for (int v = 0; v < D; v++) step(1, v, 1);
    step(0, 0, 1);

    // fwd[i] = i+3 mod 16.
    for (int i = 0; i < D; i++) write(i, (i + 3) % D, 0);
    commit();
    step(1, 3, 1); chk("inv_of_3", out_data, 0);
    step(1, 2, 1); chk("inv_of_2", out_data, 15);
    step(0, 0, 1);

    // Duplicate output -> ERR, lookups stall until fixed.
    write(5, fwd_m[6], 0);
    commit();
    chk("dup_err", table_err, 1);
    step(1, 3, 1);
    step(1, 3, 1);
    write(5, 8, 0);
    commit();
    step(1, 8, 1); chk("fixed_inv_8", out_data, 5);
    step(0, 0, 1);

    // Backpressure: held result stable, then same-cycle accept on release.
    step(1, 5, 0);
    for (int k = 0; k < 3; k++) step(1, 6, 0);
    chk("held_data", out_data, 2);
    step(1, 6, 1); chk("after_release", out_data, 3);
    step(0, 0, 1);

    // Random tables, including a write+commit in the same cycle and a non-bijective one.
    load_perm(0); rand_ticks(60);
    load_perm(1); rand_ticks(10);
    load_perm(0); rand_ticks(60);

    // Held result survives a commit; reset mid-build discards it and restores identity.
    step(1, 12, 0);
    out_ready = 0; in_valid = 0; cfg_commit = 1;
    tick();
    cfg_commit = 0;
    for (int k = 0; k < 7; k++) tick();
    chk("held_in_build", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ok", table_ok, 1);
    chk("midrst_busy", cfg_busy, 0);
    #1 rst_n = 1'b1;
    model_reset();
    step(1, 10, 1); chk("post_rst_A", out_data, 10);
    step(0, 0, 1);

`ifdef SBOX_INV_SELFCHECK_EN
    #1 dut.inv_tbl[4] = 4'h9;
    inv_m[4] = 9;
    step(1, 4, 1); chk("selfcheck_hit", chk_err, 1);
    step(1, 1, 1);
    step(0, 0, 1); chk("selfcheck_sticky", chk_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
